aes_dec_sequencer: RTL and testbench

//  Sequencer and handshake wrapper for the iterative AES-128 decryption datapath.
//  - Accepts one ciphertext/key pair over a valid/ready input port.
//  - Holds the pair stable and drives the datapath round counter through 10..20.
//  - Captures the plaintext and presents it on a valid/ready output port.
//  - Sits between the system bus adapter and the decryption core; one block in flight at a time.

---
 rtl/aes_dec_sequencer_if.sv | 50 +++++
 rtl/aes_dec_sequencer.sv | 140 ++++++++++++++
 tb/tb_aes_dec_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_dec_sequencer_if
// Bus bundle between the AES-128 decryption sequencer, its bus adapter and the
// iterative decryption datapath.
//   in_valid/in_ready/in_data/in_key  : ciphertext/key input handshake
//   out_valid/out_ready/out_data      : plaintext output handshake
//   busy                              : block in flight
//   dp_in/dp_key/dp_counter           : registered operands and round counter
//                                       driven to the datapath
//   dp_out                            : datapath result (combinational from
//                                       dp_counter)
//   abort                             : cancel, present only when
//                                       AES_DEC_SEQ_ABORT_EN is defined
// Modports: slave = sequencer view, master = environment (adapter + datapath).
// -----------------------------------------------------------------------------
interface aes_dec_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [127:0]     in_key;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             busy;
    logic [127:0]     dp_in;
    logic [127:0]     dp_key;
    logic [CNT_W-1:0] dp_counter;
    logic [127:0]     dp_out;
`ifdef AES_DEC_SEQ_ABORT_EN
    logic             abort;
`endif

    modport slave (
        input  in_valid, in_data, in_key, out_ready, dp_out,
`ifdef AES_DEC_SEQ_ABORT_EN
        input  abort,
`endif
        output in_ready, out_valid, out_data, busy, dp_in, dp_key, dp_counter
    );

    modport master (
        output in_valid, in_data, in_key, out_ready, dp_out,
`ifdef AES_DEC_SEQ_ABORT_EN
        output abort,
`endif
        input  in_ready, out_valid, out_data, busy, dp_in, dp_key, dp_counter
    );
endinterface

// File: rtl/aes_dec_sequencer.sv
// -----------------------------------------------------------------------------
// aes_dec_sequencer
// Sequencer and handshake wrapper for the iterative AES-128 decryption
// datapath. Accepts one ciphertext/key pair, holds it on dp_in/dp_key, steps
// dp_counter through CNT_FIRST..CNT_LAST, captures dp_out as the plaintext and
// offers it on the output handshake. One block in flight at a time.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : aes_dec_sequencer_if.slave (handshakes + datapath connections)
// Optional feature: define AES_DEC_SEQ_ABORT_EN to add the abort input, which
// returns the sequencer to IDLE from RUN or HOLD.
// -----------------------------------------------------------------------------
module aes_dec_sequencer #(
    parameter int CNT_W     = 6,
    parameter int CNT_FIRST = 10,
    parameter int CNT_LAST  = 20,
    parameter int CNT_PARK  = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_dec_sequencer_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(CNT_FIRST);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] C_PARK  = CNT_W'(CNT_PARK);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [127:0]     out_data_q,  out_data_d;
    logic [127:0]     dp_in_q,     dp_in_d;
    logic [127:0]     dp_key_q,    dp_key_d;
    logic             abort_w;

`ifdef AES_DEC_SEQ_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        out_data_d  = out_data_q;
        dp_in_d     = dp_in_q;
        dp_key_d    = dp_key_q;
        case (state_q)
            ST_IDLE: begin
                // abort is deliberately not looked at here: an accept in the
                // same cycle as a stray abort must still go through.
                if (bus.in_valid && in_ready_q) begin
                    dp_in_d    = bus.in_data;
                    dp_key_d   = bus.in_key;
                    cnt_d      = C_FIRST;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_w) begin
                    state_d    = ST_IDLE;
                    cnt_d      = C_PARK;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else if (cnt_q == C_LAST) begin
                    // dp_out is the final plaintext only while the counter
                    // sits at its last value; park afterwards to freeze the core.
                    out_data_d  = bus.dp_out;
                    out_valid_d = 1'b1;
                    cnt_d       = C_PARK;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // abort wins over a simultaneous output handshake
                if (abort_w) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else if (out_valid_q && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = C_PARK;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= C_PARK;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            dp_in_q     <= '0;
            dp_key_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            dp_in_q     <= dp_in_d;
            dp_key_q    <= dp_key_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.out_data   = out_data_q;
    assign bus.dp_in      = dp_in_q;
    assign bus.dp_key     = dp_key_q;
    assign bus.dp_counter = cnt_q;
endmodule

// File: tb/tb_aes_dec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_sequencer
// Directed bench for aes_dec_sequencer. A stub datapath returns the FIPS-197
// C.1 plaintext (or in^key for any other pair) only while dp_counter==20, and a
// counter-dependent junk value otherwise, so capturing at the wrong round shows
// up as a wrong plaintext.
// -----------------------------------------------------------------------------
module tb_aes_dec_sequencer;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_CT  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] V2_KEY = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    aes_dec_sequencer_if bus();

    aes_dec_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] stub_dp(input logic [127:0] din,
                                             input logic [127:0] key,
                                             input logic [5:0]   cnt);
        if (cnt == 6'd20) begin
            if (din == C1_CT && key == C1_KEY) return C1_PT;
            return din ^ key;
        end
        return ~din ^ {122'd0, cnt};
    endfunction

    always_comb bus.dp_out = stub_dp(bus.dp_in, bus.dp_key, bus.dp_counter);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a pair for one edge; returns right after the accept edge.
    task automatic do_accept(input logic [127:0] ct, input logic [127:0] key);
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        bus.in_key   = key;
        tick;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.dp_counter !== 6'd63) begin
            errors++;
            $display("FAIL reset_counter got %0d want 63", bus.dp_counter);
        end
        checks++;
        if (bus.out_data !== '0 || bus.dp_in !== '0 || bus.dp_key !== '0) begin
            errors++;
            $display("FAIL reset_data got out=%h dp_in=%h dp_key=%h want zeros",
                     bus.out_data, bus.dp_in, bus.dp_key);
        end
        $display("reset: done");
    endtask

    task automatic test_c1;
        do_accept(C1_CT, C1_KEY);
        bus.in_data = '1;   // changing inputs after accept must have no effect
        bus.in_key  = '1;
        for (int k = 0; k <= 10; k++) begin
            checks++;
            if (bus.dp_counter !== 6'(10 + k) || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL c1_trace[%0d] got cnt=%0d busy=%b vld=%b want cnt=%0d busy=1 vld=0",
                         k, bus.dp_counter, bus.busy, bus.out_valid, 10 + k);
            end
            checks++;
            if (bus.dp_in !== C1_CT || bus.dp_key !== C1_KEY) begin
                errors++;
                $display("FAIL c1_operands[%0d] got %h/%h want %h/%h",
                         k, bus.dp_in, bus.dp_key, C1_CT, C1_KEY);
            end
            tick;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== C1_PT || bus.dp_counter !== 6'd63) begin
            errors++;
            $display("FAIL c1_result got vld=%b data=%h cnt=%0d want 1 %h 63",
                     bus.out_valid, bus.out_data, bus.dp_counter, C1_PT);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL c1_release got vld=%b rdy=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        $display("c1: plaintext %h", bus.out_data);
    endtask

    task automatic test_backpressure;
        int lat;
        bus.out_ready = 1'b1;   // out_ready with no out_valid is harmless
        do_accept(V2_CT, V2_KEY);
        bus.out_ready = 1'b0;
        wait_out(lat);
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL bp_latency got %0d want 11", lat);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = C1_CT;
        bus.in_key   = C1_KEY;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== (V2_CT ^ V2_KEY) ||
                bus.in_ready !== 1'b0 || bus.dp_in !== V2_CT) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b data=%h rdy=%b dp_in=%h want 1 %h 0 %h",
                         k, bus.out_valid, bus.out_data, bus.in_ready, bus.dp_in,
                         V2_CT ^ V2_KEY, V2_CT);
            end
            tick;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dp_counter !== 6'd63) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b cnt=%0d want 0 1 63",
                     bus.out_valid, bus.in_ready, bus.dp_counter);
        end
        $display("backpressure: plaintext %h", bus.out_data);
    endtask

    task automatic test_back_to_back;
        int acc[2];
        int hs[2];
        int na = 0;
        int nh = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = C1_CT;
        bus.in_key    = C1_KEY;
        bus.out_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            if (bus.in_valid && bus.in_ready && na < 2) begin
                acc[na] = s;
                na++;
            end
            if (bus.out_valid && bus.out_ready && nh < 2) begin
                hs[nh] = s;
                checks++;
                if (bus.out_data !== C1_PT) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %h want %h", nh, bus.out_data, C1_PT);
                end
                nh++;
                if (nh == 2) bus.in_valid = 1'b0;
            end
            tick;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (na != 2 || nh != 2) begin
            errors++;
            $display("FAIL b2b_count got acc=%0d hs=%0d want 2 2", na, nh);
        end else begin
            checks++;
            if (hs[0] - acc[0] != 12 || acc[1] - hs[0] != 1 || hs[1] - acc[1] != 12) begin
                errors++;
                $display("FAIL b2b_timing got acc=%0d,%0d hs=%0d,%0d want gaps 12,1,12",
                         acc[0], acc[1], hs[0], hs[1]);
            end
        end
        $display("back_to_back: accepts %0d handshakes %0d", na, nh);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int lat;
        do_accept(C1_CT, C1_KEY);
        while (bus.dp_counter != 6'd15 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (bus.dp_counter !== 6'd15) begin
            errors++;
            $display("FAIL rmid_reach got cnt=%0d want 15", bus.dp_counter);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (bus.dp_counter !== 6'd63 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got cnt=%0d vld=%b rdy=%b busy=%b want 63 0 1 0",
                     bus.dp_counter, bus.out_valid, bus.in_ready, bus.busy);
        end
        for (int k = 0; k < 12; k++) tick;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dp_counter !== 6'd63) begin
            errors++;
            $display("FAIL rmid_quiet got vld=%b cnt=%0d want 0 63", bus.out_valid, bus.dp_counter);
        end
        do_accept(C1_CT, C1_KEY);
        wait_out(lat);
        checks++;
        if (lat != 11 || bus.out_data !== C1_PT) begin
            errors++;
            $display("FAIL rmid_after got lat=%0d data=%h want 11 %h", lat, bus.out_data, C1_PT);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        $display("reset_mid: plaintext %h", bus.out_data);
    endtask

`ifdef AES_DEC_SEQ_ABORT_EN
    task automatic test_abort;
        int n = 0;
        int lat;
        logic [127:0] last;
        last = bus.out_data;
        do_accept(V2_CT, V2_KEY);
        while (bus.dp_counter != 6'd13 && n < 20) begin
            tick;
            n++;
        end
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        checks++;
        if (bus.dp_counter !== 6'd63 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_data !== last) begin
            errors++;
            $display("FAIL abort_run got cnt=%0d rdy=%b busy=%b data=%h want 63 1 0 %h",
                     bus.dp_counter, bus.in_ready, bus.busy, bus.out_data, last);
        end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) n++;
            tick;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d valid cycles want 0", n);
        end
        // abort in IDLE alongside an accept: accept still happens
        bus.abort = 1'b1;
        do_accept(C1_CT, C1_KEY);
        bus.abort = 1'b0;
        checks++;
        if (bus.dp_counter !== 6'd10 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got cnt=%0d busy=%b want 10 1", bus.dp_counter, bus.busy);
        end
        wait_out(lat);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        bus.abort     = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.out_valid) n++;
            tick;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (n != 0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold got valid=%0d rdy=%b busy=%b want 0 1 0",
                     n, bus.in_ready, bus.busy);
        end
        $display("abort: done");
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
`ifdef AES_DEC_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        test_reset;
        test_c1;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
`ifdef AES_DEC_SEQ_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
